// File: rtl/mega_mul_iter_if.sv
`default_nettype none
// ============================================================================
// Module      : mega_mul_iter_if
// Description : Request/response bundle between the core and the iterative
//               multiplier.
//                 start, abort, mode[2:0], a, b   core -> multiplier
//                 busy, done, result[2W-1:0],      multiplier -> core
//                 flag_c, flag_z
//               The master modport is the core side; the slave modport is
//               the multiplier side.
// Revision    : 1.0  initial release
// ============================================================================
interface mega_mul_iter_if #(
  parameter int WIDTH = 8
) ();

  logic                 start;
  logic                 abort;
  logic [2:0]           mode;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic                 flag_c;
  logic                 flag_z;

  modport master (
    output start, abort, mode, a, b,
    input  busy, done, result, flag_c, flag_z
  );

  modport slave (
    input  start, abort, mode, a, b,
    output busy, done, result, flag_c, flag_z
  );

endinterface
`default_nettype wire

// File: rtl/mega_mul_iter.sv
`default_nettype none
// ============================================================================
// Module      : mega_mul_iter
// Description : Iterative shift-add multiplier for the MEGA/XMEGA core.
//               Executes MUL, MULS, MULSU, FMUL, FMULS and FMULSU on
//               WIDTH-bit operands, retiring RADIX_BITS multiplier bits per
//               clock. Result plus C/Z flags are presented with a one-cycle
//               done pulse and held until the next completion.
// Ports       : clk  - core clock, rising edge
//               rst  - asynchronous reset, active low
//               bus  - mega_mul_iter_if.slave (start/abort/mode/a/b in,
//                      busy/done/result/flag_c/flag_z out)
// Revision    : 1.0  initial release
// ============================================================================
module mega_mul_iter #(
  parameter int WIDTH      = 8,
  parameter int RADIX_BITS = 1
) (
  input  logic           clk,
  input  logic           rst,
  mega_mul_iter_if.slave bus
);

  localparam int N_STEPS = WIDTH / RADIX_BITS;
  localparam int CNT_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
  localparam int ACC_W   = 2 * WIDTH + 1;
  localparam int SUM_W   = WIDTH + RADIX_BITS + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]           state_q,  state_d;
  logic                 busy_q,   busy_d;
  logic                 done_q,   done_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 flag_c_q, flag_c_d;
  logic                 flag_z_q, flag_z_d;
  logic [ACC_W-1:0]     acc_q,    acc_d;
  logic [WIDTH-1:0]     mcand_q,  mcand_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic                 neg_q,    neg_d;
  logic                 frac_q,   frac_d;

  // --------------------------------------------------------------------------
  // Operand decode. Codes 3 and 7 have op_kind 3 and fall through to the
  // unsigned path, i.e. they execute as MUL / FMUL.
  // Negating the minimum value wraps back to 2^(WIDTH-1), which is exactly
  // the required magnitude when read as unsigned.
  // --------------------------------------------------------------------------
  logic [1:0]       op_kind;
  logic             a_signed;
  logic             b_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    op_kind  = bus.mode[1:0];
    a_signed = (op_kind == 2'd1) || (op_kind == 2'd2);
    b_signed = (op_kind == 2'd1);
    a_neg    = a_signed & bus.a[WIDTH-1];
    b_neg    = b_signed & bus.b[WIDTH-1];
    a_mag    = a_neg ? (-bus.a) : bus.a;
    b_mag    = b_neg ? (-bus.b) : bus.b;
  end

  // --------------------------------------------------------------------------
  // Right-shifting accumulator: the multiplier sits in the low WIDTH bits and
  // is consumed from the bottom while the partial product grows into the top.
  // The upper WIDTH+1 bits plus one digit*multiplicand always fit in SUM_W,
  // and after the shift the sum lands back in bits [2W:W-R].
  // --------------------------------------------------------------------------
  logic [RADIX_BITS-1:0] digit;
  logic [SUM_W-1:0]      sum;
  logic [ACC_W-1:0]      acc_shift;

  assign digit = acc_q[RADIX_BITS-1:0];
  assign sum   = SUM_W'(acc_q[ACC_W-1:WIDTH]) + (SUM_W'(mcand_q) * SUM_W'(digit));

  generate
    if (WIDTH > RADIX_BITS) begin : g_shift_lo
      assign acc_shift = {sum, acc_q[WIDTH-1:RADIX_BITS]};
    end else begin : g_single_step
      assign acc_shift = sum;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Completion: apply the sign, then the fractional left shift. C always
  // comes from the signed product before any shift.
  // --------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_signed;
  logic [2*WIDTH-1:0] res_final;

  always_comb begin
    prod_signed = neg_q ? (-acc_q[2*WIDTH-1:0]) : acc_q[2*WIDTH-1:0];
    res_final   = frac_q ? {prod_signed[2*WIDTH-2:0], 1'b0} : prod_signed;
  end

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    frac_d   = frac_q;

    case (state_q)
      S_IDLE: begin
        // abort is meaningless here; start always wins.
        if (bus.start) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
          acc_d   = ACC_W'(b_mag);
          mcand_d = a_mag;
          cnt_d   = '0;
          neg_d   = a_neg ^ b_neg;
          frac_d  = bus.mode[2];
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          acc_d = acc_shift;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(N_STEPS - 1)) begin
            state_d = S_FIN;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        // Abort here suppresses write-back so the previous result survives.
        if (!bus.abort) begin
          done_d   = 1'b1;
          result_d = res_final;
          flag_c_d = prod_signed[2*WIDTH-1];
          flag_z_d = (res_final == '0);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      frac_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      frac_q   <= frac_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.flag_c = flag_c_q;
  assign bus.flag_z = flag_z_q;

endmodule
`default_nettype wire

// File: doc/mega_mul_iter.md
Name: mega_mul_iter

Overview:
- Parametrised, multi-cycle multiplier for the MEGA/XMEGA core.
- Supports MUL, MULS, MULSU, FMUL, FMULS and FMULSU at any operand width.
- Uses a shift-add datapath that retires RADIX_BITS multiplier bits per clock. This replaces the wide single-cycle combinational product path and frees DSP/LUT area on small FPGAs.
- The core issues a start, stalls on busy and writes back result plus C/Z on the done pulse.

Parameters:
- WIDTH, 8: operand width in bits. Must be a multiple of RADIX_BITS; legal range 4 to 32.
- RADIX_BITS, 1: multiplier bits consumed per RUN cycle. Legal values are 1, 2 and 4. N = WIDTH/RADIX_BITS.

Ports:
- clk  input  1  core clock; all state changes on the rising edge.
- rst  input  1  asynchronous reset, active-low.
- start  input  1  request; sampled only when busy=0.
- abort  input  1  synchronous cancel of an in-flight operation.
- mode  input  3  0 MUL, 1 MULS, 2 MULSU, 4 FMUL, 5 FMULS, 6 FMULSU. Codes 3 and 7 are reserved and execute as 0 and 4 respectively.
- a  input  WIDTH  Rd operand; signed for modes 1, 2, 5, 6.
- b  input  WIDTH  Rr operand; signed for modes 1 and 5 only.
- busy  output  1  operation in progress.
- done  output  1  single-cycle pulse when result and flags are valid.
- result  output  2*WIDTH  product; R1:R0 when WIDTH=8.
- flag_c  output  1  C flag for write-back.
- flag_z  output  1  Z flag for write-back.

Behaviour:
- Reset: asynchronous, active-low. While rst=0 all outputs are 0 and the FSM is in IDLE, including when reset arrives mid-operation. No partial result escapes.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - An edge with start=1 latches mode, a and b.
  - Each signed operand is converted to its magnitude. For the WIDTH-bit minimum value (0x80 at WIDTH=8), the magnitude is 2^(WIDTH-1) and is kept unsigned.
  - Result sign = XOR of the operand signs that apply.
  - Product accumulator and counter are cleared. Next state is RUN and busy=1.
  - Operand inputs may change freely after the start edge.
- RUN:
  - Each edge adds (multiplier low RADIX_BITS) × multiplicand into the accumulator and shifts.
  - After exactly N RUN edges the state goes to FIN.
  - Width rule: the accumulator is 2*WIDTH+1 bits, so partial sums never overflow.
- FIN (one edge):
  - P = product, two's-complement negated if the sign is set, truncated to 2*WIDTH bits.
  - Non-fractional modes: result = P and flag_c = P[2W-1].
  - Fractional modes: flag_c = P[2W-1] and result = P<<1 (LSB 0).
  - flag_z = (final result == 0).
  - done=1 and busy=0 on the same edge. Next state is IDLE.
- Latency: done is high during the cycle following edge N+1, counted from the start-sampling edge (edge 0). Examples: WIDTH=8/RADIX_BITS=1 gives 9 edges; RADIX_BITS=2 gives 5.
- Back-to-back: start may be asserted during the done cycle and is accepted on that edge, giving zero bubble.
- start while busy=1 is ignored (not queued).
- abort:
  - When high on an edge in RUN or FIN, the next state is IDLE and busy drops on that edge.
  - done does not pulse. result/flag_c/flag_z keep their previous values.
  - abort has priority over FIN completion.
  - abort in IDLE has no effect. abort and start together in IDLE: start wins.
- Hold: result, flag_c and flag_z are stable from done until the next FIN edge. They are not cleared by a new start.
- Only the C and Z flags are produced. All other SREG bits are left unchanged by the core.

Test Plan:
- WIDTH=8, RADIX_BITS=1, MUL a=0xFF b=0xFF -> done exactly 9 edges after start; result=0xFE01, C=1, Z=0. Busy high for 9 cycles and low on the done cycle.
- MULS a=0x80 b=0x80 -> 0x4000, C=0. MULS a=0xFF b=0x01 -> 0xFFFF, C=1. MULSU a=0xFF b=0xFF -> 0xFF01, C=1. MUL a=0x00 b=0x5A -> 0x0000, Z=1, C=0.
- FMUL a=0xFF b=0xFF -> 0xFC02, C=1. FMULS a=0x80 b=0x80 -> 0x8000, C=0, Z=0. FMULSU a=0x80 b=0x40 -> 0xC000, C=1.
- RADIX_BITS=2 and WIDTH=16, MULS a=0x8000 b=0x7FFF -> 0xC0008000, C=1, done 9 edges after start. Then a new start in the done cycle is accepted, with a second done 9 edges later.
- Second start at edge 3 while busy -> ignored, only one done. Abort at edge 4 -> busy low next cycle, no done, result still holds the previous 0xFE01.
- rst low at edge 5 of an operation -> all outputs 0 immediately. After release, IDLE accepts a new start and completes normally.
